// File: rtl/seq_multiplier_param_if.sv
// Start/ready handshake and operand/result bundle for the sequential multiplier.
// The controller drives the master side; the multiplier is the slave.
interface seq_multiplier_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic                 sgn;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2*WIDTH-1:0]   Product;
   logic                 ready;
   logic                 done;

   modport master (
      output start,
      output sgn,
      output A,
      output B,
      input  Product,
      input  ready,
      input  done
   );

   modport slave (
      input  start,
      input  sgn,
      input  A,
      input  B,
      output Product,
      output ready,
      output done
   );
endinterface

// File: rtl/seq_multiplier_param.sv
// Radix-2 shift-add multiplier, WIDTH cycles per product, signed or unsigned per operation.
// Signed mode multiplies magnitudes and negates the 2*WIDTH-bit result when signs differ.
module seq_multiplier_param #(
   parameter int unsigned WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   seq_multiplier_param_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   // Upper half accumulates partial sums; lower half holds the shifting multiplier.
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic                 neg;
   logic [2*WIDTH-1:0]   product_r;
   logic                 ready_r;
   logic                 done_r;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   result;

   always_comb begin
      a_mag = bus.A;
      b_mag = bus.B;
      if (bus.sgn && bus.A[WIDTH-1]) a_mag = (~bus.A) + WIDTH'(1);
      if (bus.sgn && bus.B[WIDTH-1]) b_mag = (~bus.B) + WIDTH'(1);
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
      result   = neg ? ((~acc_next) + (2*WIDTH)'(1)) : acc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         mcand     <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         product_r <= '0;
         ready_r   <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.start) begin
                  mcand   <= a_mag;
                  acc     <= {{WIDTH{1'b0}}, b_mag};
                  cnt     <= '0;
                  neg     <= bus.sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  ready_r <= 1'b0;
                  state   <= StRun;
               end
            end
            StRun: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  product_r <= result;
                  done_r    <= 1'b1;
                  ready_r   <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.Product = product_r;
   assign bus.ready   = ready_r;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param: WIDTH=8 and WIDTH=16 instances, scoreboard queues
// filled by the drivers and drained by per-instance done monitors.
module tb_seq_multiplier_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   logic [15:0] q8[$];
   logic [31:0] q16[$];
   logic        prev_done8 = 1'b0;
   logic        prev_done16 = 1'b0;

   seq_multiplier_param_if #(.WIDTH(8))  if8 ();
   seq_multiplier_param_if #(.WIDTH(16)) if16 ();

   seq_multiplier_param #(.WIDTH(8)) dut8 (
      .clk(clk),
      .rst(rst),
      .bus(if8)
   );

   seq_multiplier_param #(.WIDTH(16)) dut16 (
      .clk(clk),
      .rst(rst),
      .bus(if16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // Monitors: every done pulse pops one expected product.
   always @(negedge clk) begin
      if (!rst) begin
         if (if8.done) begin
            chk("done8_single", {63'd0, prev_done8}, 64'd0);
            chk("ready8_at_done", {63'd0, if8.ready}, 64'd1);
            if (q8.size() == 0) fail_now("done8_unexpected");
            else chk("prod8", {48'd0, if8.Product}, {48'd0, q8.pop_front()});
         end
         prev_done8 <= if8.done;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (if16.done) begin
            chk("done16_single", {63'd0, prev_done16}, 64'd0);
            if (q16.size() == 0) fail_now("done16_unexpected");
            else chk("prod16", {32'd0, if16.Product}, {32'd0, q16.pop_front()});
         end
         prev_done16 <= if16.done;
      end
   end

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      if (s) begin
         sa = {{8{a[7]}}, a};
         sb = {{8{b[7]}}, b};
      end else begin
         sa = {8'd0, a};
         sb = {8'd0, b};
      end
      return sa * sb;
   endfunction

   task automatic wait_ready8();
      for (int i = 0; i < 50; i++) begin
         if (if8.ready) return;
         @(negedge clk);
      end
      fail_now("ready8_timeout");
   endtask

   task automatic wait_done8();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if8.done) return;
      end
      fail_now("done8_timeout");
   endtask

   task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      wait_ready8();
      if8.start = 1'b1;
      if8.sgn   = s;
      if8.A     = a;
      if8.B     = b;
      q8.push_back(exp);
      @(negedge clk);
      if8.start = 1'b0;
      if8.sgn   = 1'($urandom);
      if8.A     = 8'($urandom);
      if8.B     = 8'($urandom);
   endtask

   // Issues one WIDTH=16 op and checks that ready stays low for 16 cycles.
   task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
      int lowc = 0;
      bit seen = 0;
      for (int i = 0; i < 50 && !if16.ready; i++) @(negedge clk);
      if16.start = 1'b1;
      if16.sgn   = s;
      if16.A     = a;
      if16.B     = b;
      q16.push_back(exp);
      @(negedge clk);
      if16.start = 1'b0;
      if16.A     = 16'($urandom);
      if16.B     = 16'($urandom);
      for (int i = 0; i < 60; i++) begin
         if (if16.done) begin
            seen = 1;
            break;
         end
         if (!if16.ready) lowc++;
         @(negedge clk);
      end
      if (!seen) fail_now("done16_timeout");
      chk("lat16", 64'(lowc), 64'd16);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lowc;
      int last;
      logic       s;
      logic [7:0] a;
      logic [7:0] b;

      if8.start = 1'b0;  if8.sgn = 1'b0;  if8.A = '0;  if8.B = '0;
      if16.start = 1'b0; if16.sgn = 1'b0; if16.A = '0; if16.B = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_prod8", {48'd0, if8.Product}, 64'd0);
      chk("rst_ready8", {63'd0, if8.ready}, 64'd1);
      chk("rst_done8", {63'd0, if8.done}, 64'd0);
      chk("rst_prod16", {32'd0, if16.Product}, 64'd0);
      chk("rst_ready16", {63'd0, if16.ready}, 64'd1);
      rst = 1'b0;

      // Unsigned 0xFF*0xFF with latency measurement
      if8.start = 1'b1; if8.sgn = 1'b0; if8.A = 8'hFF; if8.B = 8'hFF;
      q8.push_back(16'hFE01);
      @(negedge clk);
      if8.start = 1'b0;
      lowc = 0;
      for (int i = 0; i < 40; i++) begin
         if (if8.done) break;
         if (!if8.ready) lowc++;
         @(negedge clk);
      end
      chk("lat8", 64'(lowc), 64'd8);
      chk("done8_high", {63'd0, if8.done}, 64'd1);
      @(negedge clk);
      chk("done8_drop", {63'd0, if8.done}, 64'd0);

      // Signed and unsigned directed vectors
      issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1); wait_done8();
      issue8(1'b1, 8'h80, 8'h80, 16'h4000); wait_done8();
      issue8(1'b1, 8'h80, 8'h7F, 16'hC080); wait_done8();
      issue8(1'b0, 8'h80, 8'h80, 16'h4000); wait_done8();
      issue8(1'b0, 8'hFD, 8'h05, 16'h04F1); wait_done8();
      issue8(1'b1, 8'h00, 8'h80, 16'h0000); wait_done8();
      issue8(1'b1, 8'hFF, 8'hFF, 16'h0001); wait_done8();

      // Busy rejection, including start on the completion edge
      @(negedge clk);
      issue8(1'b0, 8'd3, 8'd4, 16'h000C);
      for (int j = 0; j < 8; j++) begin
         if8.start = 1'b1; if8.A = 8'd9; if8.B = 8'd9;
         @(negedge clk);
      end
      if8.start = 1'b0;
      chk("busy_done", {63'd0, if8.done}, 64'd1);
      @(negedge clk);
      chk("busy_noaccept", {63'd0, if8.ready}, 64'd1);
      chk("busy_prod_hold", {48'd0, if8.Product}, 64'h000C);

      // Asynchronous reset mid-operation
      issue8(1'b0, 8'h12, 8'h34, 16'h03A8);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_prod", {48'd0, if8.Product}, 64'd0);
      chk("arst_ready", {63'd0, if8.ready}, 64'd1);
      chk("arst_done", {63'd0, if8.done}, 64'd0);
      q8.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue8(1'b0, 8'd2, 8'd3, 16'd6); wait_done8();

      // Back-to-back with start held high
      @(negedge clk);
      wait_ready8();
      s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      if8.start = 1'b1; if8.sgn = s; if8.A = a; if8.B = b;
      q8.push_back(ref8(s, a, b));
      last = 0;
      for (int i = 0; i < 100; i++) begin
         wait_done8();
         if (i > 0) chk("spacing", 64'(cyc - last), 64'd9);
         last = cyc;
         if (i < 99) begin
            s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            if8.sgn = s; if8.A = a; if8.B = b;
            q8.push_back(ref8(s, a, b));
         end else begin
            if8.start = 1'b0;
         end
      end

      // WIDTH=16 instance
      run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      @(negedge clk);
      run16(1'b1, 16'h8000, 16'hFFFF, 32'h00008000);
      @(negedge clk);
      run16(1'b1, 16'h8000, 16'h8000, 32'h40000000);

      repeat (3) @(negedge clk);
      chk("q8_empty", 64'(q8.size()), 64'd0);
      chk("q16_empty", 64'(q16.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
